// File: rtl/kmeans_pkg.sv
// Shared constants and types for the k-means centroid update path.
package kmeans_pkg;

    localparam int NUM_CENTROIDS = 7;
    localparam int FRAME_W       = 320;
    localparam int FRAME_H       = 180;
    localparam int SUM_W         = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    typedef logic [8:0] centroid_x_t;
    typedef logic [7:0] centroid_y_t;

endpackage

// File: rtl/centroid_job_sel.sv
// Maps a job index onto the division it represents: even jobs divide the
// x moment, odd jobs the y moment, both by the mass of centroid j>>1.
module centroid_job_sel
    import kmeans_pkg::*;
#(
    parameter int SUM_W = 24
) (
    input  logic [3:0]                          job_in,
    input  logic [NUM_CENTROIDS-1:0][SUM_W-1:0] x_sum_in,
    input  logic [NUM_CENTROIDS-1:0][SUM_W-1:0] y_sum_in,
    input  logic [NUM_CENTROIDS-1:0][SUM_W-1:0] mass_in,
    output logic [SUM_W-1:0]                    dividend_out,
    output logic [SUM_W-1:0]                    divisor_out,
    output logic                                zero_mass_out,
    output logic [2:0]                          idx_out
);

    logic [2:0] k;

    // Operand mux for the current job; index never exceeds 6 for legal jobs.
    always_comb begin
        k             = job_in[3:1];
        idx_out       = k;
        dividend_out  = job_in[0] ? y_sum_in[k] : x_sum_in[k];
        divisor_out   = mass_in[k];
        zero_mass_out = (mass_in[k] == '0);
    end

endmodule

// File: rtl/centroid_div_sched.sv
// Schedules the per-centroid x/y divisions onto one shared external divider,
// writing clamped quotients into the centroid registers.
// Optional feature: define DIV_TIMEOUT_EN to bound each WAIT to TIMEOUT
// cycles and expose a sticky timeout_out flag.
module centroid_div_sched
    import kmeans_pkg::*;
#(
    parameter int SUM_W   = 24,
    parameter int TIMEOUT = 64
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic                                start_in,
    input  logic [2:0]                          num_balls_in,
    input  logic [NUM_CENTROIDS-1:0][SUM_W-1:0] x_sum_in,
    input  logic [NUM_CENTROIDS-1:0][SUM_W-1:0] y_sum_in,
    input  logic [NUM_CENTROIDS-1:0][SUM_W-1:0] total_mass_in,
    input  logic                                load_in,
    input  centroid_x_t [NUM_CENTROIDS-1:0]     centroids_x_init_in,
    input  centroid_y_t [NUM_CENTROIDS-1:0]     centroids_y_init_in,
    output logic [SUM_W-1:0]                    div_dividend_out,
    output logic [SUM_W-1:0]                    div_divisor_out,
    output logic                                div_valid_out,
    input  logic                                div_busy_in,
    input  logic [SUM_W-1:0]                    div_quotient_in,
    input  logic                                div_valid_in,
    output centroid_x_t [NUM_CENTROIDS-1:0]     centroids_x_out,
    output centroid_y_t [NUM_CENTROIDS-1:0]     centroids_y_out,
    output logic                                busy_out,
`ifdef DIV_TIMEOUT_EN
    output logic                                done_out,
    output logic                                timeout_out
`else
    output logic                                done_out
`endif
);

    sched_state_t                        state_q, state_d;
    logic [3:0]                          j_q, j_d;
    logic [3:0]                          last_j_q, last_j_d;
    logic [NUM_CENTROIDS-1:0][SUM_W-1:0] x_snap_q, x_snap_d;
    logic [NUM_CENTROIDS-1:0][SUM_W-1:0] y_snap_q, y_snap_d;
    logic [NUM_CENTROIDS-1:0][SUM_W-1:0] m_snap_q, m_snap_d;
    centroid_x_t [NUM_CENTROIDS-1:0]     cx_q, cx_d;
    centroid_y_t [NUM_CENTROIDS-1:0]     cy_q, cy_d;

`ifdef DIV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    logic [SUM_W-1:0] sel_dividend, sel_divisor;
    logic             sel_zero;
    logic [2:0]       sel_idx;
    logic             issue, advance;

    centroid_job_sel #(.SUM_W(SUM_W)) u_job_sel (
        .job_in        (j_q),
        .x_sum_in      (x_snap_q),
        .y_sum_in      (y_snap_q),
        .mass_in       (m_snap_q),
        .dividend_out  (sel_dividend),
        .divisor_out   (sel_divisor),
        .zero_mass_out (sel_zero),
        .idx_out       (sel_idx)
    );

    // Quotients saturate to the frame edge rather than wrapping.
    function automatic centroid_x_t sat_x(input logic [SUM_W-1:0] q);
        return (q > SUM_W'(FRAME_W - 1)) ? centroid_x_t'(FRAME_W - 1) : q[8:0];
    endfunction

    function automatic centroid_y_t sat_y(input logic [SUM_W-1:0] q);
        return (q > SUM_W'(FRAME_H - 1)) ? centroid_y_t'(FRAME_H - 1) : q[7:0];
    endfunction

    // Next-state, job sequencing and centroid writeback.
    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        last_j_d = last_j_q;
        x_snap_d = x_snap_q;
        y_snap_d = y_snap_q;
        m_snap_d = m_snap_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        issue    = 1'b0;
        advance  = 1'b0;
`ifdef DIV_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (load_in) begin
                    cx_d = centroids_x_init_in;
                    cy_d = centroids_y_init_in;
                end
                if (start_in) begin
                    x_snap_d = x_sum_in;
                    y_snap_d = y_sum_in;
                    m_snap_d = total_mass_in;
                    j_d      = '0;
                    // Last job index is 2*n-1; irrelevant when n == 0.
                    last_j_d = {num_balls_in - 3'd1, 1'b1};
                    state_d  = (num_balls_in == 3'd0) ? DONE : ISSUE;
`ifdef DIV_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            ISSUE: begin
                if (sel_zero) begin
                    advance = 1'b1;
                end else if (!div_busy_in) begin
                    issue   = 1'b1;
                    state_d = WAIT;
`ifdef DIV_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            WAIT: begin
                if (div_valid_in) begin
                    advance = 1'b1;
                    if (j_q[0]) cy_d[sel_idx] = sat_y(div_quotient_in);
                    else        cx_d[sel_idx] = sat_x(div_quotient_in);
`ifdef DIV_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    // Abandon the job; centroid keeps its previous value.
                    advance   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (advance) begin
            if (j_q == last_j_q) begin
                state_d = DONE;
            end else begin
                j_d     = j_q + 4'd1;
                state_d = ISSUE;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            j_q      <= '0;
            last_j_q <= '0;
            x_snap_q <= '0;
            y_snap_q <= '0;
            m_snap_q <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
`ifdef DIV_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            last_j_q <= last_j_d;
            x_snap_q <= x_snap_d;
            y_snap_q <= y_snap_d;
            m_snap_q <= m_snap_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
`ifdef DIV_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Outputs: operands follow the selected job, strobes decode from state.
    always_comb begin
        div_dividend_out = sel_dividend;
        div_divisor_out  = sel_divisor;
        div_valid_out    = issue;
        centroids_x_out  = cx_q;
        centroids_y_out  = cy_q;
        busy_out         = (state_q != IDLE);
        done_out         = (state_q == DONE);
`ifdef DIV_TIMEOUT_EN
        timeout_out      = timeout_q;
`endif
    end

endmodule

// File: tb/tb_centroid_div_sched.sv
// Randomized bench for centroid_div_sched with a behavioural divider and a
// reference model that computes centroids and cycle counts arithmetically.
module tb_centroid_div_sched;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [2:0]        nb_in;
    logic [6:0][23:0]  x_sum, y_sum, mass;
    logic              load;
    logic [6:0][8:0]   cxi;
    logic [6:0][7:0]   cyi;
    logic [23:0]       dvd_o, dvs_o;
    logic              dval_o;
    logic              dbusy;
    logic [23:0]       dq;
    logic              dval;
    logic [6:0][8:0]   cx_o;
    logic [6:0][7:0]   cy_o;
    logic              busy_o, done_o;
`ifdef DIV_TIMEOUT_EN
    logic              tmo_o;
`endif

    int  xs[7], ys[7], ms[7], ref_cx[7], ref_cy[7];
    int  lat, n_issue, exp_iss, exp_cyc, total, bad;
    bit  div_mute;
    logic [23:0] m_dvd, m_dvs;

    always #5 clk = ~clk;

    centroid_div_sched dut (
        .clk_in              (clk),
        .rst_n_in            (rst_n),
        .start_in            (start),
        .num_balls_in        (nb_in),
        .x_sum_in            (x_sum),
        .y_sum_in            (y_sum),
        .total_mass_in       (mass),
        .load_in             (load),
        .centroids_x_init_in (cxi),
        .centroids_y_init_in (cyi),
        .div_dividend_out    (dvd_o),
        .div_divisor_out     (dvs_o),
        .div_valid_out       (dval_o),
        .div_busy_in         (dbusy),
        .div_quotient_in     (dq),
        .div_valid_in        (dval),
        .centroids_x_out     (cx_o),
        .centroids_y_out     (cy_o),
        .busy_out            (busy_o),
`ifdef DIV_TIMEOUT_EN
        .done_out            (done_o),
        .timeout_out         (tmo_o)
`else
        .done_out            (done_o)
`endif
    );

    // External divider: answers L cycles after each issue strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (dval_o === 1'b1) begin
                n_issue++;
                m_dvd = dvd_o;
                m_dvs = dvs_o;
                if (!div_mute) begin
                    repeat (lat) @(posedge clk);
                    #1;
                    dq   = (m_dvs == 0) ? 24'hFFFFFF : m_dvd / m_dvs;
                    dval = 1'b1;
                    @(posedge clk);
                    #1;
                    dval = 1'b0;
                end
            end
        end
    end

    // Reference: what one iteration should leave in the centroid registers,
    // how many divisions it should issue, and how long it should take.
    task automatic predict(input int nb);
        int n, s;
        n = 0;
        s = 0;
        for (int k = 0; k < nb; k++) begin
            if (ms[k] == 0) s += 2;
            else begin
                n += 2;
                ref_cx[k] = (xs[k] / ms[k] > 319) ? 319 : xs[k] / ms[k];
                ref_cy[k] = (ys[k] / ms[k] > 179) ? 179 : ys[k] / ms[k];
            end
        end
        exp_iss = n;
        exp_cyc = 1 + n * (lat + 1) + s + 1;
    endtask

    // Runs one iteration; cyc returns the index of the done cycle (start = 0).
    task automatic run_iter(input int nb, input int busy_n, input int restart_at,
                            input bit with_load, output int cyc);
        @(posedge clk); #1;
        for (int k = 0; k < 7; k++) begin
            x_sum[k] = 24'(xs[k]);
            y_sum[k] = 24'(ys[k]);
            mass[k]  = 24'(ms[k]);
        end
        nb_in   = 3'(nb);
        start   = 1'b1;
        load    = with_load;
        n_issue = 0;
        @(posedge clk); #1;
        start = 1'b0;
        load  = 1'b0;
        // Scramble inputs: only the snapshot may matter from here on.
        for (int k = 0; k < 7; k++) begin
            x_sum[k] = 24'($urandom);
            y_sum[k] = 24'($urandom);
            mass[k]  = 24'($urandom);
        end
        nb_in = 3'($urandom);
        cyc   = 1;
        dbusy = (busy_n >= 1);
        while (cyc < 3000) begin
            @(negedge clk);
            if (done_o) break;
            @(posedge clk); #1;
            cyc++;
            dbusy = (cyc <= busy_n);
            start = (cyc == restart_at);
        end
        dbusy = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 4;
        if (cx_o !== '0 || cy_o !== '0) begin bad++; $display("FAIL reset_centroids: got %h/%h want 0", cx_o, cy_o); end
        if (dval_o !== 1'b0) begin bad++; $display("FAIL reset_div_valid: got %b want 0", dval_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
`ifdef DIV_TIMEOUT_EN
        total++;
        if (tmo_o !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", tmo_o); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin ref_cx[k] = 0; ref_cy[k] = 0; end
    endtask

    task automatic test_load;
        @(posedge clk); #1;
        for (int k = 0; k < 7; k++) begin
            ref_cx[k] = $urandom_range(0, 319);
            ref_cy[k] = $urandom_range(0, 179);
            cxi[k] = 9'(ref_cx[k]);
            cyi[k] = 8'(ref_cy[k]);
        end
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            total++;
            if (int'(cx_o[k]) !== ref_cx[k] || int'(cy_o[k]) !== ref_cy[k]) begin
                bad++;
                $display("FAIL load_c%0d: got (%0d,%0d) want (%0d,%0d)", k, cx_o[k], cy_o[k], ref_cx[k], ref_cy[k]);
            end
        end
    endtask

    task automatic test_single;
        int cyc;
        lat = 13;
        for (int k = 0; k < 7; k++) begin xs[k] = 7; ys[k] = 7; ms[k] = 1; end
        xs[0] = 1600; ys[0] = 900; ms[0] = 10;
        predict(1);
        run_iter(1, 0, 0, 1'b0, cyc);
        total += 4;
        if (cx_o[0] !== 9'd160 || cy_o[0] !== 8'd90) begin bad++; $display("FAIL single_c0: got (%0d,%0d) want (160,90)", cx_o[0], cy_o[0]); end
        if (cyc + 1 !== 30) begin bad++; $display("FAIL single_cycles: got %0d want 30", cyc + 1); end
        if (n_issue !== 2) begin bad++; $display("FAIL single_issues: got %0d want 2", n_issue); end
        @(negedge clk);
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL single_done_pulse: got done=%b busy=%b want 0,0", done_o, busy_o); end
    endtask

    task automatic test_skip;
        int cyc;
        lat = 3;
        for (int k = 0; k < 7; k++) begin
            xs[k] = $urandom_range(0, 3000); ys[k] = $urandom_range(0, 1800); ms[k] = 10;
            cxi[k] = 9'(ref_cx[k]); cyi[k] = 8'(ref_cy[k]);
        end
        ms[1] = 0;
        cxi[1] = 9'd50; cyi[1] = 8'd40;
        ref_cx[1] = 50; ref_cy[1] = 40;
        predict(3);
        run_iter(3, 0, 0, 1'b1, cyc);
        total += 3;
        if (cx_o[1] !== 9'd50 || cy_o[1] !== 8'd40) begin bad++; $display("FAIL skip_c1: got (%0d,%0d) want (50,40)", cx_o[1], cy_o[1]); end
        if (n_issue !== 4) begin bad++; $display("FAIL skip_issues: got %0d want 4", n_issue); end
        if (cyc + 1 !== exp_cyc) begin bad++; $display("FAIL skip_cycles: got %0d want %0d", cyc + 1, exp_cyc); end
        for (int k = 0; k < 7; k++) begin
            total++;
            if (int'(cx_o[k]) !== ref_cx[k] || int'(cy_o[k]) !== ref_cy[k]) begin
                bad++;
                $display("FAIL skip_c%0d: got (%0d,%0d) want (%0d,%0d)", k, cx_o[k], cy_o[k], ref_cx[k], ref_cy[k]);
            end
        end
    endtask

    task automatic test_clamp;
        int cyc;
        lat = 2;
        xs[0] = 5000; ys[0] = 400; ms[0] = 1;
        xs[1] = 512;  ys[1] = 256; ms[1] = 1;
        predict(2);
        run_iter(2, 0, 0, 1'b0, cyc);
        total += 2;
        if (cx_o[0] !== 9'd319 || cy_o[0] !== 8'd179) begin bad++; $display("FAIL clamp_c0: got (%0d,%0d) want (319,179)", cx_o[0], cy_o[0]); end
        if (cx_o[1] !== 9'd319 || cy_o[1] !== 8'd179) begin bad++; $display("FAIL clamp_c1: got (%0d,%0d) want (319,179)", cx_o[1], cy_o[1]); end
    endtask

    task automatic test_busy_hold;
        int cyc;
        lat = 13;
        xs[0] = 1600; ys[0] = 900; ms[0] = 10;
        predict(1);
        run_iter(1, 5, 0, 1'b0, cyc);
        total += 3;
        if (cyc + 1 !== 35) begin bad++; $display("FAIL busy_cycles: got %0d want 35", cyc + 1); end
        if (n_issue !== 2) begin bad++; $display("FAIL busy_issues: got %0d want 2", n_issue); end
        if (cx_o[0] !== 9'd160 || cy_o[0] !== 8'd90) begin bad++; $display("FAIL busy_c0: got (%0d,%0d) want (160,90)", cx_o[0], cy_o[0]); end
    endtask

    task automatic test_zero_balls;
        int cyc;
        lat = 4;
        for (int k = 0; k < 7; k++) begin xs[k] = 100; ys[k] = 100; ms[k] = 1; end
        predict(0);
        run_iter(0, 0, 0, 1'b0, cyc);
        total += 3;
        if (cyc + 1 !== 2) begin bad++; $display("FAIL zero_balls_cycles: got %0d want 2", cyc + 1); end
        if (n_issue !== 0) begin bad++; $display("FAIL zero_balls_issues: got %0d want 0", n_issue); end
        if (int'(cx_o[0]) !== ref_cx[0]) begin bad++; $display("FAIL zero_balls_c0: got %0d want %0d", cx_o[0], ref_cx[0]); end
    endtask

    task automatic test_random;
        int cyc, nb, ra;
        for (int it = 0; it < 10; it++) begin
            lat = $urandom_range(1, 6);
            nb  = $urandom_range(0, 7);
            ra  = (it % 2 == 0) ? 3 : 0;
            for (int k = 0; k < 7; k++) begin
                ms[k] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 500);
                xs[k] = $urandom_range(0, (ms[k] + 1) * 400);
                ys[k] = $urandom_range(0, (ms[k] + 1) * 250);
            end
            predict(nb);
            run_iter(nb, 0, ra, 1'b0, cyc);
            total += 2;
            if (cyc + 1 !== exp_cyc) begin bad++; $display("FAIL rand%0d_cycles: got %0d want %0d", it, cyc + 1, exp_cyc); end
            if (n_issue !== exp_iss) begin bad++; $display("FAIL rand%0d_issues: got %0d want %0d", it, n_issue, exp_iss); end
            for (int k = 0; k < 7; k++) begin
                total++;
                if (int'(cx_o[k]) !== ref_cx[k] || int'(cy_o[k]) !== ref_cy[k]) begin
                    bad++;
                    $display("FAIL rand%0d_c%0d: got (%0d,%0d) want (%0d,%0d)", it, k, cx_o[k], cy_o[k], ref_cx[k], ref_cy[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        bit saw_done;
        lat = 13;
        xs[0] = 1600; ys[0] = 900; ms[0] = 10;
        @(posedge clk); #1;
        x_sum[0] = 24'(xs[0]); y_sum[0] = 24'(ys[0]); mass[0] = 24'(ms[0]);
        nb_in = 3'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin ref_cx[k] = 0; ref_cy[k] = 0; end
        @(negedge clk);
        total += 2;
        if (cx_o !== '0 || cy_o !== '0) begin bad++; $display("FAIL midrst_centroids: got %h/%h want 0", cx_o, cy_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done_o || busy_o) saw_done = 1'b1;
        end
        total += 2;
        if (cx_o !== '0 || cy_o !== '0) begin bad++; $display("FAIL late_result_centroids: got %h/%h want 0", cx_o, cy_o); end
        if (saw_done !== 1'b0) begin bad++; $display("FAIL late_result_activity: got %b want 0", saw_done); end
    endtask

`ifdef DIV_TIMEOUT_EN
    task automatic test_timeout;
        int cyc;
        lat = 3;
        div_mute = 1'b1;
        for (int k = 0; k < 7; k++) begin cxi[k] = 9'd77; cyi[k] = 8'd33; ref_cx[k] = 77; ref_cy[k] = 33; end
        xs[0] = 1600; ys[0] = 900; ms[0] = 10;
        run_iter(1, 0, 0, 1'b1, cyc);
        div_mute = 1'b0;
        total += 3;
        if (cyc + 1 !== 132) begin bad++; $display("FAIL tmo_cycles: got %0d want 132", cyc + 1); end
        if (tmo_o !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %b want 1", tmo_o); end
        if (cx_o[0] !== 9'd77 || cy_o[0] !== 8'd33) begin bad++; $display("FAIL tmo_c0: got (%0d,%0d) want (77,33)", cx_o[0], cy_o[0]); end
        predict(1);
        run_iter(1, 0, 0, 1'b0, cyc);
        total += 2;
        if (tmo_o !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %b want 0", tmo_o); end
        if (cx_o[0] !== 9'd160 || cy_o[0] !== 8'd90) begin bad++; $display("FAIL tmo_recover_c0: got (%0d,%0d) want (160,90)", cx_o[0], cy_o[0]); end
    endtask
`endif

    initial begin
        total = 0; bad = 0; n_issue = 0; lat = 1; div_mute = 1'b0;
        rst_n = 1'b0; start = 1'b0; load = 1'b0; nb_in = '0;
        x_sum = '0; y_sum = '0; mass = '0; cxi = '0; cyi = '0;
        dbusy = 1'b0; dq = '0; dval = 1'b0;
        test_reset;
        test_load;
        test_single;
        test_skip;
        test_clamp;
        test_busy_hold;
        test_zero_balls;
        test_random;
        test_reset_mid_wait;
`ifdef DIV_TIMEOUT_EN
        test_timeout;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/centroid_div_sched.md
# centroid_div_sched

Time-multiplexes one shared 24-bit `divider` across the up-to-14 centroid divisions (x_sum/mass, y_sum/mass for 7 centroids) at the end of each k-means iteration. Replaces 14 parallel dividers with one. It snapshots the per-centroid accumulators on `start_in`, issues one division at a time, and writes clamped quotients into the centroid registers. It then pulses `done_out` so the iteration sequencer can start the next pass.

## Interface
- `SUM_W`, 24: width of sums, mass, and divider operands.
- `TIMEOUT`, 64: cycle limit per division. Only used when `DIV_TIMEOUT_EN` is defined.
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: reset, synchronous and active-low.
- `start_in` in 1: one-cycle pulse; snapshot sums and begin scheduling.
- `num_balls_in` in 3: active centroids, 0..7; latched on start.
- `x_sum_in[6:0]` in 7×SUM_W: x moment per centroid.
- `y_sum_in[6:0]` in 7×SUM_W: y moment per centroid.
- `total_mass_in[6:0]` in 7×SUM_W: pixel count per centroid.
- `load_in` in 1: load `centroids_x_init_in` / `centroids_y_init_in`; honoured only in IDLE.
- `centroids_x_init_in[6:0]` in 7×9: initial x values.
- `centroids_y_init_in[6:0]` in 7×8: initial y values.
- `div_dividend_out` out SUM_W: operand to the divider.
- `div_divisor_out` out SUM_W: operand to the divider.
- `div_valid_out` out 1: one-cycle issue strobe.
- `div_busy_in` in 1: divider busy; no issue while high.
- `div_quotient_in` in SUM_W: divider result.
- `div_valid_in` in 1: result-valid strobe.
- `centroids_x_out[6:0]` out 7×9: registered centroids.
- `centroids_y_out[6:0]` out 7×8: registered centroids.
- `busy_out` out 1: high whenever not in IDLE.
- `done_out` out 1: one-cycle pulse when all jobs have finished.
- `timeout_out` out 1: sticky; cleared on `start_in`. Exists only with `DIV_TIMEOUT_EN`.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On `start_in`: latch all sums, masses, and `num_balls_in`; set job index j=0; go to ISSUE.
  - If `num_balls_in`=0: go directly to DONE.
  - `start_in` while not IDLE is ignored.
  - If `load_in` and `start_in` are asserted together, `load_in` takes effect and the start still proceeds.
- **Job mapping:** job j targets centroid k=j>>1. Even j computes x_sum[k]/mass[k]; odd j computes y_sum[k]/mass[k]. Last job is 2·num_balls−1.
- **ISSUE**
  - If mass[k]==0: skip. Centroid keeps its previous value; j advances; the skip costs 1 cycle.
  - Else, if `!div_busy_in`: drive operands, assert `div_valid_out` for 1 cycle, go to WAIT.
  - Else: hold in ISSUE.
  - Operands are valid whenever `div_valid_out` is high.
- **WAIT**
  - On `div_valid_in`: write the quotient and advance j.
  - x results clamp to 319; y results clamp to 179. The upper quotient bits saturate; they are not truncated.
  - After the last job, go to DONE; otherwise go to ISSUE.
- **DONE:** `done_out`=1 for one cycle, then go to IDLE.
- **Result strobes:** a `div_valid_in` arriving outside WAIT is ignored.
- **Reset**
  - Outputs: centroids all 0, `div_valid_out`=0, `busy_out`=0, `done_out`=0, `timeout_out`=0, state IDLE.
  - Reset in the middle of a job abandons it. A late `div_valid_in` after reset is ignored.

## Timing
- `start_in` sampled at edge 0 → ISSUE during cycle 1 → `div_valid_out` in cycle 1 if the divider is idle.
- Divider latency L = cycles from `div_valid_out` to `div_valid_in`.
- Per nonzero job: 1 + L cycles. Per skipped job: 1 cycle.
- The centroid register updates on the edge that samples `div_valid_in`.
- `done_out` is high in the cycle after the last writeback.
- Total = 1 + ΣN(L+1) + skips + 1, where ΣN is the number of nonzero jobs.
- For 7 balls, L=13, no skips: 1 + 14·14 + 1 = 198 cycles.

## Configuration
- `DIV_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - At TIMEOUT cycles with no `div_valid_in`: keep the old centroid value, set `timeout_out`, advance j.
  - Counter resets on every issue.
- `DIV_TIMEOUT_EN` undefined: WAIT waits indefinitely; no `timeout_out` port and no counter.

## Structure
- **Package `kmeans_pkg`**
  - Constants: `NUM_CENTROIDS`=7, `FRAME_W`=320, `FRAME_H`=180, `SUM_W`=24.
  - Typedefs: `sched_state_t` enum; `centroid_x_t` (9b); `centroid_y_t` (8b).
- **Sub-module `centroid_job_sel`** (combinational)
  - Input: j and the snapshot arrays.
  - Output: dividend, divisor, zero-mass flag, target index.
- The divider is external to the block, shared via the handshake above.

## Test plan
- **Single job:** num_balls=1, x_sum=1600, y_sum=900, mass=10, L=13 → centroid0=(160,90); `done_out` exactly 30 cycles after start.
- **Zero-mass skip:** num_balls=3, mass1=0 → centroid1 unchanged from load value (50,40); exactly 4 `div_valid_out` pulses issued.
- **Clamp:** x_sum=5000, mass=1 → x=319; y_sum=400, mass=1 → y=179.
- **Busy hold:** `div_busy_in` high for 5 cycles at issue → `div_valid_out` is delayed 5 cycles; no duplicate issue.
- **Control edge cases:**
  - `start_in` while busy is ignored.
  - num_balls=0 → `done_out` 2 cycles after start.
  - Reset mid-WAIT → all centroids 0; late `div_valid_in` causes no change.
- **Timeout (`DIV_TIMEOUT_EN`, TIMEOUT=64):** divider never responds → centroid keeps its old value, `timeout_out`=1, `done_out` follows.
